// File: rtl/csr_regfile_if.sv
// csr_regfile_if: the write-back stage's connection to the CSR register file.
//   CSR access: csr_num, csr_we, csr_wmask, csr_wvalue (from write-back) and
//               csr_rvalue (combinational read data back to write-back).
//   Commit:     ws_ex, ws_pc, ws_ecode, ws_esubcode, ws_vaddr and ertn.
//   Results:    has_int, ex_entry and era_entry, returned to write-back.
// The master modport is the write-back stage. The slave modport is the register file.
interface csr_regfile_if;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        ws_ex;
  logic [31:0] ws_pc;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_vaddr;
  logic        ertn;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_entry;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    output ws_ex, ws_pc, ws_ecode, ws_esubcode, ws_vaddr, ertn,
    input  csr_rvalue, has_int, ex_entry, era_entry
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    input  ws_ex, ws_pc, ws_ecode, ws_esubcode, ws_vaddr, ertn,
    output csr_rvalue, has_int, ex_entry, era_entry
  );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: control/status register file for the LoongArch-style pipeline.
// It serves combinational CSR reads and applies masked CSR writes.
// It records exception and ertn state, and it runs the constant timer.
// It samples the interrupt lines every cycle.
//
// Ports:
//   clk, reset  clock; asynchronous active-high reset.
//   bus         csr_regfile_if slave port, carrying the CSR access and commit
//               signals from write-back and the results sent back to it.
//   hw_int_in   hardware interrupt lines (level), sampled into ESTAT.IS[9:2].
//   ipi_int_in  inter-processor interrupt (level), sampled into ESTAT.IS[12].
module csr_regfile #(
  parameter int          TIMER_W   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  csr_regfile_if.slave bus,
  input  logic [7:0]   hw_int_in,
  input  logic         ipi_int_in
);

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  logic [8:0]         crmd_reg;
  logic [2:0]         prmd_reg;
  logic [12:0]        ecfg_lie_reg;
  logic [1:0]         is_sw_reg;
  logic [7:0]         is_hw_reg;
  logic               is_timer_reg;
  logic               is_ipi_reg;
  logic [5:0]         ecode_reg;
  logic [8:0]         esubcode_reg;
  logic [31:0]        era_reg;
  logic [31:0]        badv_reg;
  logic [25:0]        eentry_reg;
  logic [31:0]        save_reg [4];
  logic [31:0]        tid_reg;
  logic [TIMER_W-1:0] tcfg_reg;
  logic [TIMER_W-1:0] tval_reg;

  logic [12:0]        estat_is;
  logic [31:0]        rvalue;
  logic [31:0]        wmerged;
  logic               wr_en;
  logic               tcfg_wr;
  logic               ticlr_hit;
  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] tval_next;
  logic               timer_fire;

  assign estat_is = {is_ipi_reg, is_timer_reg, 1'b0, is_hw_reg, is_sw_reg};

  always_comb begin
    rvalue = 32'h0;
    case (bus.csr_num)
      CSR_CRMD:    rvalue = 32'(crmd_reg);
      CSR_PRMD:    rvalue = 32'(prmd_reg);
      CSR_ECFG:    rvalue = 32'(ecfg_lie_reg);
      CSR_ESTAT:   rvalue = {1'b0, esubcode_reg, ecode_reg, 3'b000, estat_is};
      CSR_ERA:     rvalue = era_reg;
      CSR_BADV:    rvalue = badv_reg;
      CSR_EENTRY:  rvalue = {eentry_reg, 6'b0};
      CSR_SAVE0:   rvalue = save_reg[0];
      CSR_SAVE0+1: rvalue = save_reg[1];
      CSR_SAVE0+2: rvalue = save_reg[2];
      CSR_SAVE0+3: rvalue = save_reg[3];
      CSR_TID:     rvalue = tid_reg;
      CSR_TCFG:    rvalue = 32'(tcfg_reg);
      CSR_TVAL:    rvalue = 32'(tval_reg);
      default:     rvalue = 32'h0;
    endcase
  end

  // rvalue already carries zeros in read-only and reserved positions.
  // Each register below therefore only needs to pick its writable slice.
  assign wmerged   = (rvalue & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign wr_en     = bus.csr_we & ~bus.ws_ex & ~bus.ertn;
  assign tcfg_wr   = wr_en && (bus.csr_num == CSR_TCFG);
  assign ticlr_hit = wr_en && (bus.csr_num == CSR_TICLR) && wmerged[0];
  assign tcfg_new  = wmerged[TIMER_W-1:0];

  // Timer: a TCFG write reloads, otherwise count down. A periodic timer
  // spends one cycle at zero before reloading, so the period is 4*InitVal+1.
  always_comb begin
    tval_next  = tval_reg;
    timer_fire = 1'b0;
    if (tcfg_wr) begin
      tval_next = {tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (tcfg_reg[0] && (tval_reg != '0)) begin
      tval_next  = tval_reg - TIMER_W'(1);
      timer_fire = (tval_reg == TIMER_W'(1));
    end else if (tcfg_reg[0] && tcfg_reg[1]) begin
      tval_next = {tcfg_reg[TIMER_W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_reg     <= 9'h8;
      prmd_reg     <= '0;
      ecfg_lie_reg <= '0;
      is_sw_reg    <= '0;
      is_hw_reg    <= '0;
      is_timer_reg <= 1'b0;
      is_ipi_reg   <= 1'b0;
      ecode_reg    <= '0;
      esubcode_reg <= '0;
      era_reg      <= '0;
      badv_reg     <= '0;
      eentry_reg   <= '0;
      tid_reg      <= TID_RESET;
      tcfg_reg     <= '0;
      tval_reg     <= '0;
    end else begin
      is_hw_reg  <= hw_int_in;
      is_ipi_reg <= ipi_int_in;
      tval_reg   <= tval_next;
      // A timer expiry in the same cycle as a TICLR clear keeps the flag set.
      if (timer_fire)     is_timer_reg <= 1'b1;
      else if (ticlr_hit) is_timer_reg <= 1'b0;

      if (bus.ws_ex) begin
        prmd_reg      <= {crmd_reg[2], crmd_reg[1:0]};
        crmd_reg[2:0] <= 3'b000;
        era_reg       <= bus.ws_pc;
        ecode_reg     <= bus.ws_ecode;
        esubcode_reg  <= bus.ws_esubcode;
        if (bus.ws_ecode == 6'h8 && bus.ws_esubcode == 9'h0) badv_reg <= bus.ws_pc;
        else if (bus.ws_ecode == 6'h9)                       badv_reg <= bus.ws_vaddr;
      end else if (bus.ertn) begin
        crmd_reg[2:0] <= prmd_reg;
      end else if (bus.csr_we) begin
        case (bus.csr_num)
          CSR_CRMD:   crmd_reg     <= wmerged[8:0];
          CSR_PRMD:   prmd_reg     <= wmerged[2:0];
          CSR_ECFG:   ecfg_lie_reg <= wmerged[12:0] & 13'h1BFF;
          CSR_ESTAT:  is_sw_reg    <= wmerged[1:0];
          CSR_ERA:    era_reg      <= wmerged;
          CSR_BADV:   badv_reg     <= wmerged;
          CSR_EENTRY: eentry_reg   <= wmerged[31:6];
          CSR_TID:    tid_reg      <= wmerged;
          CSR_TCFG:   tcfg_reg     <= tcfg_new;
          default:    ;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_save
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          save_reg[gi] <= '0;
        else if (wr_en && bus.csr_num == CSR_SAVE0 + 14'(gi))
          save_reg[gi] <= wmerged;
      end
    end
  endgenerate

  assign bus.csr_rvalue = rvalue;
  assign bus.has_int    = crmd_reg[2] & |(estat_is & ecfg_lie_reg);
  assign bus.ex_entry   = {eentry_reg, 6'b0};
  assign bus.era_entry  = era_reg;

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;
  logic clk;
  logic reset;
  logic [7:0] hw_int_in;
  logic ipi_int_in;
  int n_checks;
  int n_fail;
  logic [31:0] v;

  csr_regfile_if bus();

  csr_regfile #(.TIMER_W(32), .TID_RESET(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [13:0] n, output logic [31:0] val);
    bus.csr_num = n;
    #1;
    val = bus.csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] d);
    bus.csr_we = 1'b1; bus.csr_num = n; bus.csr_wmask = m; bus.csr_wvalue = d;
    tick();
    bus.csr_we = 1'b0;
    $display("write csr=%h mask=%h data=%h", n, m, d);
  endtask

  task automatic ex(input logic [31:0] pc, input logic [5:0] ec, input logic [8:0] esc,
                    input logic [31:0] va);
    bus.ws_ex = 1'b1; bus.ws_pc = pc; bus.ws_ecode = ec; bus.ws_esubcode = esc; bus.ws_vaddr = va;
    tick();
    bus.ws_ex = 1'b0;
    $display("exception pc=%h ecode=%h esub=%h vaddr=%h", pc, ec, esc, va);
  endtask

  task automatic test_reset();
    rd(14'h0, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL reset_crmd: got %h expected %h", v, 32'h8); end
    rd(14'h40, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_tid: got %h expected %h", v, 32'h0); end
    rd(14'h123, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", v); end
    n_checks++;
    if (bus.has_int !== 1'b0) begin n_fail++; $display("FAIL reset_has_int: got %b expected 0", bus.has_int); end
    n_checks++;
    if (bus.ex_entry !== 32'h0 || bus.era_entry !== 32'h0) begin
      n_fail++; $display("FAIL reset_entries: got %h/%h expected 0/0", bus.ex_entry, bus.era_entry);
    end
  endtask

  task automatic test_masked_write();
    wr(14'h0, 32'h4, 32'h7);
    rd(14'h0, v); n_checks++;
    if (v !== 32'hC) begin n_fail++; $display("FAIL crmd_masked: got %h expected %h", v, 32'hC); end
    wr(14'hC, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'hC, v); n_checks++;
    if (v !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL eentry: got %h expected %h", v, 32'hFFFFFFC0); end
    n_checks++;
    if (bus.ex_entry !== 32'hFFFFFFC0) begin n_fail++; $display("FAIL ex_entry: got %h expected %h", bus.ex_entry, 32'hFFFFFFC0); end
    wr(14'h123, 32'hFFFFFFFF, 32'h55);
    rd(14'h123, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_write: got %h expected 0", v); end
    wr(14'h4, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h4, v); n_checks++;
    if (v !== 32'h1BFF) begin n_fail++; $display("FAIL ecfg_mask: got %h expected %h", v, 32'h1BFF); end
    wr(14'h4, 32'hFFFFFFFF, 32'h0);
    wr(14'h5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    rd(14'h5, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL estat_sw_mask: got %h expected %h", v, 32'h3); end
    wr(14'h5, 32'hFFFFFFFF, 32'h0);
  endtask

  task automatic test_hw_int();
    hw_int_in = 8'h05; ipi_int_in = 1'b1;
    tick();
    rd(14'h5, v); n_checks++;
    if (v[12:0] !== 13'h1014) begin n_fail++; $display("FAIL hw_int_sample: got %h expected %h", v[12:0], 13'h1014); end
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    wr(14'h0, 32'hFFFFFFFF, 32'hF);
    ex(32'h1C000100, 6'hB, 9'h0, 32'h0);
    rd(14'h0, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL ex_crmd: got %h expected %h", v, 32'h8); end
    rd(14'h1, v); n_checks++;
    if (v !== 32'h7) begin n_fail++; $display("FAIL ex_prmd: got %h expected %h", v, 32'h7); end
    rd(14'h6, v); n_checks++;
    if (v !== 32'h1C000100 || bus.era_entry !== 32'h1C000100) begin
      n_fail++; $display("FAIL ex_era: got %h/%h expected %h", v, bus.era_entry, 32'h1C000100);
    end
    tick();
    rd(14'h5, v); n_checks++;
    if (v[21:16] !== 6'hB) begin n_fail++; $display("FAIL ex_ecode: got %h expected %h", v[21:16], 6'hB); end
    bus.ertn = 1'b1; tick(); bus.ertn = 1'b0;
    $display("ertn");
    rd(14'h0, v); n_checks++;
    if (v !== 32'hF) begin n_fail++; $display("FAIL ertn_crmd: got %h expected %h", v, 32'hF); end
  endtask

  task automatic test_badv();
    ex(32'h1C000050, 6'h9, 9'h0, 32'h80001003);
    rd(14'h7, v); n_checks++;
    if (v !== 32'h80001003) begin n_fail++; $display("FAIL badv_ale: got %h expected %h", v, 32'h80001003); end
    ex(32'h1C000004, 6'h8, 9'h0, 32'h12345678);
    rd(14'h7, v); n_checks++;
    if (v !== 32'h1C000004) begin n_fail++; $display("FAIL badv_adef: got %h expected %h", v, 32'h1C000004); end
    ex(32'h1C000200, 6'hB, 9'h0, 32'hABCDEF00);
    rd(14'h7, v); n_checks++;
    if (v !== 32'h1C000004) begin n_fail++; $display("FAIL badv_hold: got %h expected %h", v, 32'h1C000004); end
  endtask

  task automatic test_timer();
    wr(14'h0, 32'h4, 32'h4);
    wr(14'h4, 32'hFFFFFFFF, 32'h800);
    wr(14'h41, 32'hFFFFFFFF, 32'h9);
    rd(14'h42, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL tval_load: got %h expected %h", v, 32'h8); end
    repeat (7) tick();
    rd(14'h42, v); n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL tval_count: got %h expected %h", v, 32'h1); end
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b0 || bus.has_int !== 1'b0) begin
      n_fail++; $display("FAIL timer_early: got is11=%b has_int=%b expected 0/0", v[11], bus.has_int);
    end
    tick();
    rd(14'h42, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL tval_zero: got %h expected 0", v); end
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b1 || bus.has_int !== 1'b1) begin
      n_fail++; $display("FAIL timer_fire: got is11=%b has_int=%b expected 1/1", v[11], bus.has_int);
    end
    wr(14'h44, 32'hFFFFFFFF, 32'h1);
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b0 || bus.has_int !== 1'b0) begin
      n_fail++; $display("FAIL ticlr: got is11=%b has_int=%b expected 0/0", v[11], bus.has_int);
    end
    repeat (12) tick();
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL oneshot_no_refire: got %b expected 0", v[11]); end
    rd(14'h42, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL oneshot_hold: got %h expected 0", v); end
  endtask

  task automatic test_periodic();
    wr(14'h41, 32'hFFFFFFFF, 32'hB);
    repeat (8) tick();
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b1) begin n_fail++; $display("FAIL periodic_first: got %b expected 1", v[11]); end
    wr(14'h44, 32'hFFFFFFFF, 32'h1);
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL periodic_clear: got %b expected 0", v[11]); end
    rd(14'h42, v); n_checks++;
    if (v !== 32'h8) begin n_fail++; $display("FAIL periodic_reload: got %h expected %h", v, 32'h8); end
    repeat (7) tick();
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b0) begin n_fail++; $display("FAIL periodic_early: got %b expected 0", v[11]); end
    tick();
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b1) begin n_fail++; $display("FAIL periodic_second: got %b expected 1", v[11]); end
    // Clear on the cycle of the next 1->0 transition: the set must win.
    repeat (8) tick();
    rd(14'h42, v); n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL periodic_pre: got %h expected %h", v, 32'h1); end
    wr(14'h44, 32'hFFFFFFFF, 32'h1);
    rd(14'h5, v); n_checks++;
    if (v[11] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", v[11]); end
    wr(14'h41, 32'hFFFFFFFF, 32'h0);
    wr(14'h44, 32'hFFFFFFFF, 32'h1);
  endtask

  task automatic test_priority();
    wr(14'h30, 32'hFFFFFFFF, 32'h12345678);
    bus.csr_we = 1'b1; bus.csr_num = 14'h30; bus.csr_wmask = 32'hFFFFFFFF; bus.csr_wvalue = 32'hDEADBEEF;
    bus.ws_ex = 1'b1; bus.ws_pc = 32'h1C000300; bus.ws_ecode = 6'h1; bus.ws_esubcode = 9'h0;
    tick();
    bus.csr_we = 1'b0; bus.ws_ex = 1'b0;
    $display("write save0 with exception");
    rd(14'h30, v); n_checks++;
    if (v !== 32'h12345678) begin n_fail++; $display("FAIL save0_ex_prio: got %h expected %h", v, 32'h12345678); end
    bus.csr_we = 1'b1; bus.csr_num = 14'h31; bus.csr_wvalue = 32'hCAFEF00D; bus.ertn = 1'b1;
    tick();
    bus.csr_we = 1'b0; bus.ertn = 1'b0;
    $display("write save1 with ertn");
    rd(14'h31, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL save1_ertn_prio: got %h expected 0", v); end
  endtask

  task automatic test_async_reset();
    wr(14'h41, 32'hFFFFFFFF, 32'h9);
    repeat (3) tick();
    #2 reset = 1'b1;
    rd(14'h42, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL async_tval: got %h expected 0", v); end
    rd(14'h41, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL async_tcfg: got %h expected 0", v); end
    rd(14'h30, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL async_save0: got %h expected 0", v); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; hw_int_in = 8'h0; ipi_int_in = 1'b0;
    bus.csr_num = 14'h0; bus.csr_we = 1'b0; bus.csr_wmask = 32'h0; bus.csr_wvalue = 32'h0;
    bus.ws_ex = 1'b0; bus.ws_pc = 32'h0; bus.ws_ecode = 6'h0; bus.ws_esubcode = 9'h0;
    bus.ws_vaddr = 32'h0; bus.ertn = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    test_reset();
    tick();
    test_masked_write();
    test_hw_int();
    test_exception();
    test_badv();
    test_timer();
    test_periodic();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file for the LoongArch-style pipeline.
- Acts as the responder for the write-back stage's CSR port. It serves combinational CSR reads and applies masked CSR writes.
- Records exception and ertn state, runs the constant timer, and samples interrupt lines.
- Drives has_int, the exception entry address and the return address back to write-back.

Parameters:
TIMER_W, 32, width of the TCFG.InitVal+2 field and of TVAL (legal range 8..32)
TID_RESET, 32'h0, reset value of TID

Ports:
clk  input  1  clock
reset  input  1  reset
csr_num  input  14  CSR number for both read and write
csr_rvalue  output  32  read data for csr_num, combinational
csr_we  input  1  CSR write strobe, already qualified by stage valid
csr_wmask  input  32  per-bit write mask
csr_wvalue  input  32  write data
ws_ex  input  1  exception committed this cycle
ws_pc  input  32  PC of the committing instruction
ws_ecode  input  6  exception code
ws_esubcode  input  9  exception subcode
ws_vaddr  input  32  faulting data address for ALE
ertn  input  1  ertn committed this cycle
has_int  output  1  enabled interrupt pending
ex_entry  output  32  exception entry (EENTRY)
era_entry  output  32  return address (ERA)
hw_int_in  input  8  hardware interrupt lines, level
ipi_int_in  input  1  inter-processor interrupt, level

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high; all state clears immediately on reset assertion.
- Masked write rule: new = (old & ~wmask) | (wvalue & wmask), then ANDed with the register's writable mask. Read-only and reserved bits read 0 unless stated.
- CRMD (0x0): PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7].
  - Reset: DA=1, all other fields 0 (value 0x8).
  - Writable mask: 0x1FF.
- PRMD (0x1): PPLV[1:0], PIE[2]. Reset 0.
- ECFG (0x4): LIE[12:0], bit 10 reserved. Writable mask 0x1BFF. Reset 0.
- ESTAT (0x5):
  - IS[1:0] is software-writable.
  - IS[9:2] is registered from hw_int_in every cycle.
  - IS[10] is 0.
  - IS[11] is the timer interrupt flag.
  - IS[12] is registered from ipi_int_in.
  - Ecode[21:16] and EsubCode[30:22] are written only by exceptions.
  - Writable mask via csr_we: 0x3. Reset 0.
- ERA (0x6), BADV (0x7), SAVE0-3 (0x30-0x33): full 32-bit, reset 0.
- EENTRY (0xC): bits [31:6] writable, [5:0] read 0. Reset 0.
- TID (0x40): full writable, reset TID_RESET.
- TCFG (0x41): En[0], Periodic[1], InitVal[TIMER_W-1:2]. Reset 0.
- TVAL (0x42): read-only timer counter, upper bits above TIMER_W read 0. Reset 0.
- TICLR (0x44): reads 0. Writing 1 to bit 0 (after mask) clears ESTAT.IS[11].
- Unmapped csr_num: read returns 0; write is ignored.
- Exception (ws_ex=1), in the same cycle:
  - PRMD.PPLV<=CRMD.PLV and PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0 and CRMD.IE<=0.
  - ERA<=ws_pc.
  - ESTAT.Ecode<=ws_ecode and ESTAT.EsubCode<=ws_esubcode.
  - If ecode=ADE(0x8) and esubcode=ADEF(0), BADV<=ws_pc.
  - If ecode=ALE(0x9), BADV<=ws_vaddr.
- ertn=1: CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE.
- Priority: ws_ex > ertn > csr_we. A csr_we coinciding with ws_ex or ertn is discarded entirely.
- Timer, evaluated each cycle:
  - A TCFG write loads TVAL <= {InitVal_new, 2'b00}. The write takes priority over counting.
  - Otherwise, if En=1 and TVAL!=0: TVAL <= TVAL-1.
  - On the cycle TVAL goes 1->0, set ESTAT.IS[11].
  - If En=1, Periodic=1 and TVAL==0: reload TVAL <= {InitVal,2'b00}. Period is 4*InitVal+1 cycles.
  - Non-periodic: TVAL holds at 0 and no further interrupts are raised.
  - If a TICLR clear and a timer set occur in the same cycle, the set wins.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Combinational from registered state, reset value 0.
- Outputs:
  - ex_entry = EENTRY and era_entry = ERA, both 0 after reset.
  - csr_rvalue reflects state before this cycle's write (read-before-write).
- A reset asserted mid-count clears TVAL, TCFG and IS[11] immediately.

Test Plan:
1. Reset, then read 0x0 -> 0x00000008. Read 0x40 -> TID_RESET. Read 0x123 -> 0. has_int=0.
2. Write CRMD wvalue=0x7 wmask=0x4 -> CRMD reads 0xC. Write EENTRY 0xFFFFFFFF full mask -> reads 0xFFFFFFC0 and ex_entry=0xFFFFFFC0.
3. With CRMD.PLV=3, IE=1, pulse ws_ex with pc=0x1C000100, ecode=0xB -> CRMD[2:0]=0, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0xB. Then pulse ertn -> CRMD.PLV=3, IE=1.
4. ws_ex with ecode=0x9 and ws_vaddr=0x80001003 -> BADV=0x80001003. ws_ex with ecode=0x8, esubcode=0, pc=0x1C000004 -> BADV=0x1C000004.
5. Write TCFG=0x9 (En=1, InitVal=2) -> TVAL=8, counts down to 0 in 8 cycles, IS[11]=1. With ECFG.LIE[11]=1 and IE=1, has_int=1. Then write TICLR=1 -> IS[11]=0 and has_int=0.
6. TCFG=0xB (periodic) -> IS[11] re-sets every 9 cycles. Timer set coincident with TICLR -> IS[11] stays 1. csr_we to SAVE0 coincident with ws_ex -> SAVE0 unchanged.
